// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Holds the FSM state enum, widths and the divide-by-zero quotient.
package div_pkg;

    localparam int DW    = 8;
    localparam int STEPS = 8;

    localparam logic [DW-1:0] DBZ_QUOT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    // Two's-complement negate; 0x80 maps to itself (magnitude 128).
    function automatic logic [DW-1:0] neg(input logic [DW-1:0] x);
        return ~x + 1'b1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
// Ports: rin/dvs/din in -> rout (new remainder), qbit (quotient bit).
module div_step
    import div_pkg::*;
(
    input  logic [DW:0]   rin,
    input  logic [DW-1:0] dvs,
    input  logic          din,
    output logic [DW:0]   rout,
    output logic          qbit
);

    logic [DW:0]   sh;
    logic [DW+1:0] wide;
    logic [DW+1:0] diff;

    // rin[DW] is always 0 between steps (R < divisor); keeping it in
    // the wide form makes the borrow test exact for any input.
    assign sh   = {rin[DW-1:0], din};
    assign wide = {rin[DW], sh};
    assign diff = wide - {2'b00, dvs};

    assign qbit = ~diff[DW+1];
    assign rout = qbit ? diff[DW:0] : sh;

endmodule

// File: rtl/seq_divider.sv
// 8-bit sequential restoring divider, unsigned or signed, 1 bit/clk.
// Ports: clk, rst_n, start/sgn/dividend/divisor in; busy, done,
//        quotient, remainder, dbz, ovf out (all registered).
module seq_divider
    import div_pkg::*;
#(
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          sgn,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          dbz,
    output logic          ovf
);

    localparam logic [2:0] LAST = 3'(STEPS - 1);

    state_t        state;
    logic [2:0]    cnt;
    logic [DW:0]   r;
    logic [DW-1:0] dq;
    logic [DW-1:0] dvs;
    logic [DW-1:0] a_raw;
    logic          qneg;
    logic          rneg;
    logic          dbz_p;
    logic          ovf_p;

    logic          ssel;
    logic [DW:0]   step_r;
    logic          step_q;

    assign ssel = SIGNED_EN && sgn;

    // dq holds the dividend magnitude; quotient bits shift in at the
    // bottom as dividend bits leave from the top.
    div_step u_step (
        .rin  (r),
        .dvs  (dvs),
        .din  (dq[DW-1]),
        .rout (step_r),
        .qbit (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            r         <= '0;
            dq        <= '0;
            dvs       <= '0;
            a_raw     <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            dbz_p     <= 1'b0;
            ovf_p     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dq    <= (ssel && dividend[DW-1])
                                 ? neg(dividend) : dividend;
                        dvs   <= (ssel && divisor[DW-1])
                                 ? neg(divisor) : divisor;
                        qneg  <= ssel
                                 && (dividend[DW-1] ^ divisor[DW-1]);
                        rneg  <= ssel && dividend[DW-1];
                        dbz_p <= (divisor == '0);
                        ovf_p <= ssel && (dividend == 8'h80)
                                 && (divisor == 8'hFF);
                        a_raw <= dividend;
                        r     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= (divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    r   <= step_r;
                    dq  <= {dq[DW-2:0], step_q};
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dbz_p) begin
                        quotient  <= DBZ_QUOT;
                        remainder <= a_raw;
                        dbz       <= 1'b1;
                        ovf       <= 1'b0;
                    end else begin
                        // -128/-1 wraps naturally to 0x80 here.
                        quotient  <= qneg ? neg(dq) : dq;
                        remainder <= rneg ? neg(r[DW-1:0])
                                          : r[DW-1:0];
                        dbz       <= 1'b0;
                        ovf       <= ovf_p;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
